// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause/dim controller (pause_dim_ctl).
// Holds the dimming FSM state enum and the width helpers used by the top and the timer.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        DIM  = 2'd2
    } pause_state_e;

    // Width of the dim_level port; never narrower than one bit.
    function automatic int dim_level_w(input int steps);
        int w;
        w = $clog2(steps + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int timer_w(input int dim_cycles, input int step_cycles);
        return $clog2(((dim_cycles > step_cycles) ? dim_cycles : step_cycles) + 1);
    endfunction

endpackage

// File: rtl/pause_dim_timer.sv
// Saturating pause timer plus the target dim-level counter.
// Only instantiated when the dimming feature (PAUSE_DIM_EN) is built.
module pause_dim_timer
    import pause_pkg::*;
#(
    parameter int TW        = 8,
    parameter int DIM_STEPS = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              first_i,
    input  logic                              step_i,
    output logic [TW-1:0]                     timer_o,
    output logic [dim_level_w(DIM_STEPS)-1:0] level_o
);

    localparam int LW = dim_level_w(DIM_STEPS);
    localparam logic [TW-1:0] TIMER_MAX = '1;
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DIM_STEPS);

    logic [TW-1:0] timer_q;
    logic [LW-1:0] level_q;

    // Clear wins over everything so an unpause never leaves a stale level behind.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            timer_q <= '0;
            level_q <= '0;
        end else if (first_i) begin
            timer_q <= '0;
            level_q <= LW'(1);
        end else if (step_i) begin
            timer_q <= '0;
            if (level_q < LEVEL_MAX) begin
                level_q <= level_q + LW'(1);
            end
        end else if (timer_q != TIMER_MAX) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    assign timer_o = timer_q;
    assign level_o = level_q;

endmodule

// File: rtl/pause_dim_ctl.sv
// Pause controller with optional screen dimming after a long user pause.
// Dimming is built only when the macro PAUSE_DIM_EN is defined; otherwise colour is a registered passthrough.
module pause_dim_ctl
    import pause_pkg::*;
#(
    parameter int RW          = 2,
    parameter int GW          = 2,
    parameter int BW          = 2,
    parameter int NUM_SRC     = 2,
    parameter int DIM_CYCLES  = 32'h68E7780,
    parameter int STEP_CYCLES = 11000000,
    parameter int DIM_STEPS   = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              btn_pause,
    input  logic [NUM_SRC-1:0]                src_pause,
    input  logic                              vblank,
    input  logic [RW-1:0]                     r_in,
    input  logic [GW-1:0]                     g_in,
    input  logic [BW-1:0]                     b_in,
    output logic [RW-1:0]                     r_out,
    output logic [GW-1:0]                     g_out,
    output logic [BW-1:0]                     b_out,
    output logic                              pause,
    output logic                              user_paused,
    output logic [dim_level_w(DIM_STEPS)-1:0] dim_level
);

    localparam int LW = dim_level_w(DIM_STEPS);

    logic          btn_q;
    logic          user_paused_q;
    logic          user_paused_d;
    logic          pause_q;
    logic          toggle;
    logic [LW-1:0] dim_d;
    logic [RW-1:0] r_q;
    logic [GW-1:0] g_q;
    logic [BW-1:0] b_q;

    assign toggle        = btn_pause & ~btn_q;
    assign user_paused_d = user_paused_q ^ toggle;

    // Pause uses the next toggle state so user_paused and pause move on the same clock.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_q         <= 1'b0;
            user_paused_q <= 1'b0;
            pause_q       <= 1'b0;
        end else begin
            btn_q         <= btn_pause;
            user_paused_q <= user_paused_d;
            pause_q       <= user_paused_d | (|src_pause);
        end
    end

`ifdef PAUSE_DIM_EN
    localparam int TW = timer_w(DIM_CYCLES, STEP_CYCLES);
    localparam logic [TW-1:0] DIM_LAST  = TW'(DIM_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);

    pause_state_e  state_q;
    logic          vblank_q;
    logic [LW-1:0] dim_q;
    logic [TW-1:0] timer;
    logic [LW-1:0] level;
    logic          leave;
    logic          tmr_clear;
    logic          tmr_first;
    logic          tmr_step;

    // A toggle while paused always returns to RUN, ahead of any timer event.
    assign leave     = toggle & user_paused_q;
    assign tmr_clear = (state_q == RUN) | leave;
    assign tmr_first = (state_q == WAIT) & (timer >= DIM_LAST);
    assign tmr_step  = (state_q == DIM) & (timer >= STEP_LAST);

    pause_dim_timer #(
        .TW        (TW),
        .DIM_STEPS (DIM_STEPS)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (tmr_clear),
        .first_i (tmr_first),
        .step_i  (tmr_step),
        .timer_o (timer),
        .level_o (level)
    );

    // Brightness only changes at a vblank rising edge, except the immediate restore on unpause.
    always_comb begin
        dim_d = dim_q;
        if (leave || (state_q == RUN)) begin
            dim_d = '0;
        end else if (vblank && !vblank_q) begin
            dim_d = level;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= RUN;
            vblank_q <= 1'b0;
            dim_q    <= '0;
        end else begin
            vblank_q <= vblank;
            dim_q    <= dim_d;
            if (leave) begin
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN:     if (toggle) state_q <= WAIT;
                    WAIT:    if (tmr_first) state_q <= DIM;
                    DIM:     state_q <= DIM;
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign dim_level = dim_q;
`else
    logic unused_nodim;

    assign unused_nodim = vblank ^ (DIM_CYCLES > STEP_CYCLES);
    assign dim_d        = '0;
    assign dim_level    = '0;
`endif

    // The shift uses the level being registered this clock, so colour and dim_level change together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
        end else begin
            r_q <= r_in >> dim_d;
            g_q <= g_in >> dim_d;
            b_q <= b_in >> dim_d;
        end
    end

    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign pause       = pause_q;
    assign user_paused = user_paused_q;

endmodule
